// File: rtl/fp_add_pkg.sv
// Shared definitions for the FP adder front end: field widths, operand class
// encodings and the operand bundle carried between stages.
package fp_add_pkg;

    localparam int unsigned EXP_W_DEFAULT = 8;
    localparam int unsigned MAN_W_DEFAULT = 28;

    typedef enum logic [1:0] {
        CLS_SUB     = 2'b00,
        CLS_NOR_A   = 2'b01,
        CLS_NOR_B   = 2'b10,
        CLS_SPECIAL = 2'b11
    } opClass_t;

    typedef struct packed {
        logic                     sa;
        logic                     sb;
        logic                     c;
        logic [EXP_W_DEFAULT-1:0] e;
        logic [MAN_W_DEFAULT-1:0] a;
        logic [MAN_W_DEFAULT-1:0] b;
        logic                     special;
    } operandBundle_t;

endpackage

// File: rtl/operand_class_mux.sv
// Picks the subnormal or normal operand bundle from the operand class and
// forces the all-ones exponent for Inf/NaN operands.
module operand_class_mux
    import fp_add_pkg::*;
#(
    parameter int unsigned EXP_W = EXP_W_DEFAULT,
    parameter int unsigned MAN_W = MAN_W_DEFAULT
) (
    input  logic             subSa,
    input  logic             subSb,
    input  logic             subComp,
    input  logic [EXP_W-1:0] subE,
    input  logic [MAN_W-1:0] subMa,
    input  logic [MAN_W-1:0] subMb,
    input  logic             norSa,
    input  logic             norSb,
    input  logic             norComp,
    input  logic [EXP_W-1:0] norE,
    input  logic [MAN_W-1:0] norMa,
    input  logic [MAN_W-1:0] norMb,
    input  logic [1:0]       eData,
    output logic             selSa_c,
    output logic             selSb_c,
    output logic             selC_c,
    output logic [EXP_W-1:0] selE_c,
    output logic [MAN_W-1:0] selA_c,
    output logic [MAN_W-1:0] selB_c,
    output logic             selSpecial_c
);

    always_comb begin
        selSa_c      = subSa;
        selSb_c      = subSb;
        selC_c       = subComp;
        selE_c       = subE;
        selA_c       = subMa;
        selB_c       = subMb;
        selSpecial_c = 1'b0;
        case (eData)
            CLS_NOR_A, CLS_NOR_B: begin
                selSa_c = norSa;
                selSb_c = norSb;
                selC_c  = norComp;
                selE_c  = norE;
                selA_c  = norMa;
                selB_c  = norMb;
            end
            CLS_SPECIAL: begin
                selSa_c      = norSa;
                selSb_c      = norSb;
                selC_c       = norComp;
                selE_c       = '1;
                selA_c       = norMa;
                selB_c       = norMb;
                selSpecial_c = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/adder_operand_stage.sv
// Operand selection stage of the FP adder, buffered by a 2-entry main/skid
// FIFO whose head register drives the outputs directly.
module adder_operand_stage
    import fp_add_pkg::*;
#(
    parameter int unsigned EXP_W = EXP_W_DEFAULT,
    parameter int unsigned MAN_W = MAN_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sub_sa,
    input  logic             sub_sb,
    input  logic             sub_comp,
    input  logic [EXP_W-1:0] sub_e,
    input  logic [MAN_W-1:0] sub_ma,
    input  logic [MAN_W-1:0] sub_mb,
    input  logic             nor_sa,
    input  logic             nor_sb,
    input  logic             nor_comp,
    input  logic [EXP_W-1:0] nor_e,
    input  logic [MAN_W-1:0] nor_ma,
    input  logic [MAN_W-1:0] nor_mb,
    input  logic [1:0]       e_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sa,
    output logic             sb,
    output logic             c,
    output logic [EXP_W-1:0] e,
    output logic [MAN_W-1:0] a,
    output logic [MAN_W-1:0] b,
    output logic             special
);

    typedef struct packed {
        logic             sa;
        logic             sb;
        logic             c;
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] a;
        logic [MAN_W-1:0] b;
        logic             special;
    } stageEntry_t;

    logic             selSa, selSb, selC, selSpecial;
    logic [EXP_W-1:0] selE;
    logic [MAN_W-1:0] selA, selB;

    stageEntry_t inEntry, head, skid, headNext, skidNext;
    logic [1:0]  count, countNext;
    logic        push, pop;

    operand_class_mux #(
        .EXP_W(EXP_W),
        .MAN_W(MAN_W)
    ) u_mux (
        .subSa       (sub_sa),
        .subSb       (sub_sb),
        .subComp     (sub_comp),
        .subE        (sub_e),
        .subMa       (sub_ma),
        .subMb       (sub_mb),
        .norSa       (nor_sa),
        .norSb       (nor_sb),
        .norComp     (nor_comp),
        .norE        (nor_e),
        .norMa       (nor_ma),
        .norMb       (nor_mb),
        .eData       (e_data),
        .selSa_c     (selSa),
        .selSb_c     (selSb),
        .selC_c      (selC),
        .selE_c      (selE),
        .selA_c      (selA),
        .selB_c      (selB),
        .selSpecial_c(selSpecial)
    );

    assign inEntry = '{sa: selSa, sb: selSb, c: selC, e: selE,
                       a: selA, b: selB, special: selSpecial};

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // Push+pop only coexist at count 1, where the new entry replaces the head.
    always_comb begin
        countNext = count;
        headNext  = head;
        skidNext  = skid;
        if (flush) begin
            countNext = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) headNext = inEntry;
                    else               skidNext = inEntry;
                    countNext = count + 2'd1;
                end
                2'b01: begin
                    headNext  = skid;
                    countNext = count - 2'd1;
                end
                2'b11: headNext = inEntry;
                default: ;
            endcase
        end
    end

    // Handshake flags are decoded from the next count so they stay registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= 2'd0;
            head      <= '0;
            skid      <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            count     <= countNext;
            head      <= headNext;
            skid      <= skidNext;
            out_valid <= (countNext != 2'd0);
            in_ready  <= (countNext != 2'd2);
        end
    end

    assign sa      = head.sa;
    assign sb      = head.sb;
    assign c       = head.c;
    assign e       = head.e;
    assign a       = head.a;
    assign b       = head.b;
    assign special = head.special;

endmodule

// File: tb/tb_adder_operand_stage.sv
// Directed self-checking bench for adder_operand_stage with hand-computed
// expected values.
module tb_adder_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        sub_sa, sub_sb, sub_comp;
    logic [7:0]  sub_e;
    logic [27:0] sub_ma, sub_mb;
    logic        nor_sa, nor_sb, nor_comp;
    logic [7:0]  nor_e;
    logic [27:0] nor_ma, nor_mb;
    logic [1:0]  e_data;
    logic        out_valid;
    logic        out_ready;
    logic        sa, sb, c;
    logic [7:0]  e;
    logic [27:0] a, b;
    logic        special;

    int errors = 0;
    int checks = 0;

    adder_operand_stage dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sub_sa   (sub_sa),
        .sub_sb   (sub_sb),
        .sub_comp (sub_comp),
        .sub_e    (sub_e),
        .sub_ma   (sub_ma),
        .sub_mb   (sub_mb),
        .nor_sa   (nor_sa),
        .nor_sb   (nor_sb),
        .nor_comp (nor_comp),
        .nor_e    (nor_e),
        .nor_ma   (nor_ma),
        .nor_mb   (nor_mb),
        .e_data   (e_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sa       (sa),
        .sb       (sb),
        .c        (c),
        .e        (e),
        .a        (a),
        .b        (b),
        .special  (special)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        sub_sa = 1'b0; sub_sb = 1'b0; sub_comp = 1'b0; sub_e = 8'h00;
        sub_ma = 28'h0; sub_mb = 28'h0;
        nor_sa = 1'b0; nor_sb = 1'b0; nor_comp = 1'b0; nor_e = 8'h00;
        nor_ma = 28'h0; nor_mb = 28'h0; e_data = 2'b00;
        #1 rst_n = 1'b0;
        #6;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_a",         64'(a),         64'd0);
        chk("rst_e",         64'(e),         64'd0);
        chk("rst_special",   64'(special),   64'd0);
        #5 rst_n = 1'b1;

        // Single subnormal transfer
        tick();
        sub_sa = 1'b1; sub_sb = 1'b0; sub_comp = 1'b1; sub_e = 8'h00;
        sub_ma = 28'h0000123; sub_mb = 28'h0000456;
        nor_sa = 1'b0; nor_e = 8'h33; nor_ma = 28'hAAAAAAA; nor_mb = 28'h5555555;
        e_data = 2'b00; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("sub_out_valid", 64'(out_valid), 64'd1);
        chk("sub_e",         64'(e),         64'h00);
        chk("sub_a",         64'(a),         64'h0000123);
        chk("sub_b",         64'(b),         64'h0000456);
        chk("sub_sa",        64'(sa),        64'd1);
        chk("sub_c",         64'(c),         64'd1);
        chk("sub_special",   64'(special),   64'd0);
        tick();
        chk("sub_drained",   64'(out_valid), 64'd0);

        // Special class
        nor_sa = 1'b0; nor_sb = 1'b1; nor_comp = 1'b1; nor_e = 8'h05;
        nor_ma = 28'h89ABCDE; nor_mb = 28'h0F0F0F0; sub_e = 8'h77;
        e_data = 2'b11; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("spc_e",       64'(e),       64'hFF);
        chk("spc_special", 64'(special), 64'd1);
        chk("spc_a",       64'(a),       64'h89ABCDE);
        chk("spc_b",       64'(b),       64'h0F0F0F0);
        chk("spc_sb",      64'(sb),      64'd1);
        chk("spc_c",       64'(c),       64'd1);
        tick();
        chk("spc_drained", 64'(out_valid), 64'd0);

        // Backpressure: three offered, two accepted, drain in order
        out_ready = 1'b0;
        e_data = 2'b01; nor_e = 8'h11; nor_ma = 28'h1; in_valid = 1'b1;
        tick();
        chk("bp1_in_ready", 64'(in_ready), 64'd1);
        chk("bp1_a",        64'(a),        64'h1);
        e_data = 2'b10; nor_e = 8'h22; nor_ma = 28'h2;
        tick();
        chk("bp2_in_ready", 64'(in_ready), 64'd0);
        chk("bp2_a_hold",   64'(a),        64'h1);
        e_data = 2'b00; sub_e = 8'h33; sub_ma = 28'h3;
        tick();
        chk("bp3_in_ready", 64'(in_ready), 64'd0);
        chk("bp3_a_hold",   64'(a),        64'h1);
        chk("bp3_e_hold",   64'(e),        64'h11);
        out_ready = 1'b1;
        tick();
        chk("bp4_in_ready", 64'(in_ready), 64'd1);
        chk("bp4_a",        64'(a),        64'h2);
        chk("bp4_e",        64'(e),        64'h22);
        tick();
        in_valid = 1'b0;
        chk("bp5_a",        64'(a),        64'h3);
        chk("bp5_e",        64'(e),        64'h33);
        chk("bp5_valid",    64'(out_valid), 64'd1);
        tick();
        chk("bp6_drained",  64'(out_valid), 64'd0);

        // Streaming: 16 back-to-back entries, alternating normal classes
        sub_e = 8'hEE; sub_ma = 28'hEEEEEEE;
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            e_data = (i % 2 == 0) ? 2'b01 : 2'b10;
            nor_e  = 8'(i);
            nor_ma = 28'h1000000 + 28'(i);
            tick();
            chk("str_valid", 64'(out_valid), 64'd1);
            chk("str_e",     64'(e),         64'(i));
            chk("str_a",     64'(a),         64'h1000000 + 64'(i));
            chk("str_spc",   64'(special),   64'd0);
        end
        in_valid = 1'b0;
        tick();
        chk("str_drained", 64'(out_valid), 64'd0);

        // Flush at full occupancy with a push offered
        out_ready = 1'b0; e_data = 2'b01; in_valid = 1'b1;
        tick();
        tick();
        chk("fl_full_in_ready", 64'(in_ready), 64'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_out_valid", 64'(out_valid), 64'd0);
        chk("fl_in_ready",  64'(in_ready),  64'd1);

        // Flush beats a same-cycle push at count 1
        in_valid = 1'b1;
        tick();
        chk("fl1_valid", 64'(out_valid), 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl1_out_valid", 64'(out_valid), 64'd0);
        tick();
        chk("fl1_still_empty", 64'(out_valid), 64'd0);

        // Asynchronous reset mid-cycle with one entry buffered
        e_data = 2'b01; nor_sa = 1'b1; nor_e = 8'h5A; nor_ma = 28'hABCDEF1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("ar_pre_valid", 64'(out_valid), 64'd1);
        chk("ar_pre_a",     64'(a),         64'hABCDEF1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_out_valid", 64'(out_valid), 64'd0);
        chk("ar_in_ready",  64'(in_ready),  64'd1);
        chk("ar_a",         64'(a),         64'd0);
        chk("ar_e",         64'(e),         64'd0);
        chk("ar_sa",        64'(sa),        64'd0);
        #2 rst_n = 1'b1;

        // Fresh entry after reset
        out_ready = 1'b1; e_data = 2'b10; nor_e = 8'h42; nor_ma = 28'h0000777; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("pr_valid", 64'(out_valid), 64'd1);
        chk("pr_e",     64'(e),         64'h42);
        chk("pr_a",     64'(a),         64'h0000777);
        tick();
        chk("pr_drained", 64'(out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adder_operand_stage.md
ADDER_OPERAND_STAGE -- requirements
Module: adder_operand_stage

Interface
REQ-001 Parameter EXP_W, default 8, exponent field width.
REQ-002 Parameter MAN_W, default 28, aligned mantissa width (hidden, guard, round and sticky bits included).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 flush  input  1  synchronous clear of all buffered entries.
REQ-006 in_valid  input  1; in_ready  output  1  upstream handshake; a transfer occurs when both are 1 at a rising edge.
REQ-007 sub_sa, sub_sb, sub_comp  input  1 each  subnormal-path signs and compare flag.
REQ-008 sub_e  input  EXP_W; sub_ma, sub_mb  input  MAN_W each  subnormal-path exponent and mantissas.
REQ-009 nor_sa, nor_sb, nor_comp  input  1 each; nor_e  input  EXP_W; nor_ma, nor_mb  input  MAN_W each  normal-path fields.
REQ-010 e_data  input  2  operand class: 00 subnormal, 01 or 10 normal, 11 special (Inf/NaN).
REQ-011 out_valid  output  1; out_ready  input  1  downstream handshake, same transfer rule as upstream.
REQ-012 sa, sb, c  output  1 each; e  output  EXP_W; a, b  output  MAN_W each  selected operand bundle.
REQ-013 special  output  1  selected entry is class 11.

Function
REQ-014 Selection: e_data 00 selects the sub_* bundle; 01 or 10 selects the nor_* bundle; special = 0 in both cases.
REQ-015 e_data 11 selects nor_sa, nor_sb, nor_comp, nor_ma and nor_mb, forces e to all ones, and sets special = 1; no output ever carries X.
REQ-016 Each selected bundle plus its special bit is one entry, written into a 2-entry FIFO (main plus skid) on every upstream transfer.
REQ-017 in_ready = 1 exactly when the registered occupancy count is below 2, so in_ready has no combinational path from out_ready.
REQ-018 out_valid = 1 exactly when count is not 0; the output fields always present the oldest entry.
REQ-019 Latency: an entry accepted at edge N is presented at the outputs with out_valid = 1 immediately after edge N when the FIFO was empty.
REQ-020 Count update per edge: push alone increments; pop alone decrements; push and pop together leave the count unchanged and advance the head; neither holds all state.
REQ-021 With count = 2, no push occurs; a pop at count 2 makes in_ready = 1 on the following cycle.
REQ-022 Output fields stay stable while out_valid = 1 and out_ready = 0.
REQ-023 Order is preserved: entries leave in the order they were accepted.
REQ-024 flush = 1 sets count to 0 at the next edge and discards any same-cycle push or pop; flush has priority over both.
REQ-025 Sustained throughput is one entry per cycle when out_ready stays at 1.

Reset
REQ-026 rst_n low clears count to 0 immediately: out_valid = 0, in_ready = 1.
REQ-027 During reset, all entry storage is 0, so sa, sb, c, e, a, b and special read as 0.
REQ-028 Reset asserted mid-transfer drops all buffered entries; the first accept after rst_n rises is treated as a fresh entry.

Structure
REQ-029 A shared package fp_add_pkg holds the EXP_W and MAN_W defaults, the e_data class encodings (CLS_SUB, CLS_NOR_A, CLS_NOR_B, CLS_SPECIAL) and the operand-bundle struct.
REQ-030 The selection logic is the sub-module operand_class_mux (combinational, parametrised by EXP_W and MAN_W); the FIFO and control logic stay in adder_operand_stage.

Verification
REQ-031 Reset then a single transfer (e_data=00, sub_e=8'h00, sub_ma=28'h0000123), out_ready=1 -> next cycle out_valid=1, e=8'h00, a=28'h0000123, special=0.
REQ-032 e_data=11 with nor_e=8'h05 -> e=8'hFF, special=1, a=nor_ma.
REQ-033 out_ready=0 with 3 pushes offered -> 2 accepted, then in_ready=0; out_ready=1 -> entries drain in order and in_ready returns 1 one cycle after the first pop.
REQ-034 Continuous traffic with in_valid=1 and out_ready=1 for 16 cycles -> 16 outputs with no bubbles, alternating classes 01 and 10 select nor_* each time.
REQ-035 flush asserted with count=2 and a simultaneous push -> next cycle count=0, out_valid=0, in_ready=1.
REQ-036 rst_n pulsed low asynchronously mid-cycle with count=1 -> out_valid falls without waiting for a clock edge and all outputs are 0.
